// File: rtl/core_reset_seq.sv
// Reset sequencer for the NEXT186 core: power-on hold, debounced button and
// OSD reset requests, minimum-width stretched core reset, saturating reset counter.
module core_reset_seq #(
  parameter int unsigned POR_CYCLES      = 65536,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MIN_PULSE       = 1024,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk_cpu,
  input  logic       reset_n,
  input  logic       osd_reset,
  input  logic       button,
  output logic       core_reset,
  output logic       core_reset_n,
  output logic       released,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {
    S_POR,
    S_RUN,
    S_HOLD,
    S_STRETCH
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);

  logic             r_osd_meta;
  logic             r_osd_s;
  logic             r_btn_meta;
  logic             r_btn_s;
  logic             r_button_db;
  logic [CNT_W-1:0] r_dcnt;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_core_reset;
  logic             r_core_reset_n;
  logic             r_released;
  logic [7:0]       r_reset_count;

  logic             w_req;
  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [7:0]       w_next_count;

  // A button change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      r_osd_meta  <= 1'b0;
      r_osd_s     <= 1'b0;
      r_btn_meta  <= 1'b0;
      r_btn_s     <= 1'b0;
      r_button_db <= 1'b0;
      r_dcnt      <= '0;
    end else begin
      r_osd_meta <= osd_reset;
      r_osd_s    <= r_osd_meta;
      r_btn_meta <= button;
      r_btn_s    <= r_btn_meta;
      if (r_btn_s != r_button_db) begin
        if (r_dcnt == DEB_LAST) begin
          r_button_db <= r_btn_s;
          r_dcnt      <= '0;
        end else begin
          r_dcnt <= r_dcnt + CNT_W'(1);
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign w_req = r_osd_s | r_button_db;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_count = r_reset_count;
    case (r_state)
      S_POR: begin
        if (r_cnt == POR_LAST) begin
          w_next_cnt   = '0;
          w_next_state = w_req ? S_HOLD : S_RUN;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_next_cnt = '0;
        if (w_req) begin
          w_next_state = S_HOLD;
          if (r_reset_count != 8'hFF) begin
            w_next_count = r_reset_count + 8'd1;
          end
        end
      end
      S_HOLD: begin
        w_next_cnt = '0;
        if (!w_req) begin
          w_next_state = S_STRETCH;
        end
      end
      S_STRETCH: begin
        if (w_req) begin
          w_next_state = S_HOLD;
          w_next_cnt   = '0;
        end else if (r_cnt == PULSE_LAST) begin
          w_next_state = S_RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_POR;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs come from flops fed by next_state so they never glitch and align with the state change.
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_POR;
      r_cnt          <= '0;
      r_core_reset   <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_released     <= 1'b0;
      r_reset_count  <= '0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_reset_count  <= w_next_count;
      r_core_reset   <= (w_next_state != S_RUN);
      r_core_reset_n <= (w_next_state == S_RUN);
      r_released     <= (w_next_state == S_RUN) && (r_state != S_RUN);
    end
  end

  assign core_reset   = r_core_reset;
  assign core_reset_n = r_core_reset_n;
  assign released     = r_released;
  assign reset_count  = r_reset_count;

endmodule
